// File: rtl/rx_packet_buffer.sv
// rx_packet_buffer: packet-aware receive FIFO; bytes are written speculatively,
// committed (CRC stripped) on a good DATA code and rolled back on error.
module rx_packet_buffer #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [2:0]        RX_packet,
  input  logic              store_RX_packet_data,
  input  logic [7:0]        RX_packet_data,
  input  logic              get_rx_data,
  input  logic              flush,
  input  logic              clear_status,
  output logic [7:0]        rx_data,
  output logic              rx_data_valid,
  output logic [ADDR_W:0]   buffer_occupancy,
  output logic [2:0]        rx_packet_status,
  output logic              rx_packet_new,
  output logic              rx_overflow
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] LP_DEPTH = PW'(DEPTH);
  localparam logic [PW-1:0] LP_TWO   = PW'(2);
  localparam logic [PW-1:0] LP_ONE   = PW'(1);

  typedef enum logic {IDLE, RECV} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_cptr, r_rptr, r_occ;
  logic [2:0]    r_prev, r_status;
  logic [7:0]    r_data;
  logic          r_valid, r_new, r_ovf, r_pkt_bad;

  logic          w_cap, w_token, w_full, w_st_ok, w_drop;
  logic          w_commit, w_commit_ok, w_rollback, w_abort, w_pop;
  logic [2:0]    w_code;
  logic [PW-1:0] w_wst, w_pend;

  always_comb begin
    w_code   = (RX_packet == 3'b111) ? 3'b110 : RX_packet;
    w_cap    = (RX_packet != 3'b000) && (RX_packet != r_prev);
    w_token  = w_code inside {3'b001, 3'b010, 3'b100, 3'b101};
    w_full   = (r_wptr - r_rptr) >= LP_DEPTH;
    w_st_ok  = store_RX_packet_data & ~w_full;
    w_drop   = store_RX_packet_data & w_full;
    // pending length includes a byte landing in the same cycle
    w_wst    = r_wptr + (w_st_ok ? LP_ONE : '0);
    w_pend   = w_wst - r_cptr;
    w_commit = w_cap && (w_code == 3'b011);
    w_commit_ok = w_commit && (w_pend >= LP_TWO)
                  && !(r_pkt_bad | w_drop);
    w_rollback = w_cap && ((w_code == 3'b110)
                 || (w_token && r_state == RECV));
    w_abort  = (w_commit & ~w_commit_ok) | w_rollback;
    w_pop    = get_rx_data && (r_cptr != r_rptr);
    w_state_nxt = r_state;
    if (flush)
      w_state_nxt = IDLE;
    else if (w_commit || w_rollback)
      w_state_nxt = IDLE;
    else if (store_RX_packet_data)
      w_state_nxt = RECV;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!flush && w_st_ok)
      r_mem[r_wptr[ADDR_W-1:0]] <= RX_packet_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr    <= '0;
      r_cptr    <= '0;
      r_rptr    <= '0;
      r_occ     <= '0;
      r_prev    <= 3'b000;
      r_status  <= 3'b000;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_new     <= 1'b0;
      r_ovf     <= 1'b0;
      r_pkt_bad <= 1'b0;
    end else begin
      r_prev <= RX_packet;
      if (flush) begin
        r_wptr    <= '0;
        r_cptr    <= '0;
        r_rptr    <= '0;
        r_occ     <= '0;
        r_valid   <= 1'b0;
        r_new     <= 1'b0;
        r_ovf     <= 1'b0;
        r_pkt_bad <= 1'b0;
      end else begin
        r_valid <= w_pop;
        r_occ   <= r_cptr - r_rptr;
        if (w_pop) begin
          r_data <= r_mem[r_rptr[ADDR_W-1:0]];
          r_rptr <= r_rptr + LP_ONE;
        end
        if (w_drop) r_ovf <= 1'b1;
        unique case (1'b1)
          w_commit_ok: begin
            r_cptr    <= w_wst - LP_TWO;
            r_wptr    <= w_wst - LP_TWO;
            r_pkt_bad <= 1'b0;
          end
          w_abort: begin
            r_wptr    <= r_cptr;
            r_pkt_bad <= 1'b0;
          end
          default: begin
            r_wptr    <= w_wst;
            r_pkt_bad <= r_pkt_bad | w_drop;
          end
        endcase
        if (w_cap) begin
          r_new    <= 1'b1;
          r_status <= (w_commit && !w_commit_ok) ? 3'b110 : w_code;
        end else if (clear_status) begin
          r_new <= 1'b0;
        end
      end
    end
  end

  assign rx_data          = r_data;
  assign rx_data_valid    = r_valid;
  assign buffer_occupancy = r_occ;
  assign rx_packet_status = r_status;
  assign rx_packet_new    = r_new;
  assign rx_overflow      = r_ovf;

endmodule
